ring_osc_sweep_ctrl: RTL and testbench
======================================

# ring_osc_sweep_ctrl

Measurement sequencer for the tapped ring oscillator. It steps the ring's tap select through a programmed range. For each tap it enables the ring, waits a settle period, then counts oscillator rising edges over a fixed window of `clk` cycles. Each (tap, count) result is offered on a valid/ready port. It sits between the host-facing register/IO logic and the ring's `tap`/enable inputs, and replaces direct pin control of the ring.

## Interface
- `CNT_W`, default 16: width of the edge counter and `result_count`.
- `GATE_W`, default 16: width of `gate_len`.
- `SETTLE_CYC`, default 16: settle cycles after enabling the ring on a tap (≥1).
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin sweep; accepted only in IDLE.
- `abort` in 1: cancel sweep from any state.
- `tap_first` in 3: first tap; sampled on accepted `start`.
- `tap_last` in 3: last tap, inclusive; sampled on accepted `start`.
- `gate_len` in GATE_W: gate window in `clk` cycles; sampled on accepted `start`; 0 is treated as 1.
- `osc_in` in 1: ring output after the external prescaler; asynchronous to `clk`; frequency must be < f_clk/4.
- `osc_en` out 1: ring enable.
- `tap` out 3: ring tap select.
- `busy` out 1: high in any state except IDLE.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `result_tap` out 3: tap of the current result.
- `result_count` out CNT_W: edge count of the current result.
- `done` out 1: one-cycle pulse when the last result is accepted.

## Operation
- States: IDLE, SETTLE, GATE, REPORT, OFF.
- IDLE: `osc_en`=0, `busy`=0. When `start`=1, latch `tap_first`/`tap_last`/`gate_len`, set `tap`=`tap_first`, clear the settle counter, go to SETTLE.
- SETTLE: `osc_en`=1. Run for exactly SETTLE_CYC cycles, then go to GATE with the edge counter cleared.
- GATE: `osc_en`=1. Run for exactly max(`gate_len`,1) cycles. Count each cycle where the detected edge is high, then go to REPORT.
- Edge detect: 2-flop synchronizer s1→s2, then delay flop s3. The edge signal is s2 & ~s3. Sync flops run in every state; there is no reset in the data path beyond `rst`.
- Counter saturates at 2^CNT_W−1 and does not wrap.
- REPORT: `osc_en`=1, `result_valid`=1. `result_tap`/`result_count` are held stable until `result_valid`&`result_ready`. On handshake:
  - if `tap`==`tap_last`: pulse `done`, go to IDLE (`osc_en`=0).
  - else: `tap` ← `tap`+1 mod 8, go to OFF.
- OFF: `osc_en`=0 for exactly 1 cycle, which resets the ring before the new tap. Then go to SETTLE.
- Tap order increments mod 8 from `tap_first` to `tap_last` inclusive. Equal values give a single point. `tap_first` > `tap_last` wraps: 6→1 measures 6,7,0,1.
- `abort`=1 in any non-IDLE state: next state is IDLE, `osc_en`=0, `result_valid`=0, no `done`. `abort` has priority over `start` and the handshake.
- `start` while busy is ignored.
- Reset values: state IDLE, `osc_en`=0, `tap`=0, `busy`=0, `result_valid`=0, `result_tap`=0, `result_count`=0, `done`=0, sync flops 0.

## Timing
- All outputs are registered.
- `start` sampled at edge N: `busy`=1, `osc_en`=1, `tap`=`tap_first` from N+1.
- GATE begins at N+1+SETTLE_CYC. `result_valid` rises at N+1+SETTLE_CYC+max(`gate_len`,1).
- `osc_in` edge-to-count latency is 3 cycles. Edges whose detect pulse lands in a GATE cycle are counted, so edges in the last 3 cycles of SETTLE are counted and the final 3 cycles of GATE miss their edges. This fixed skew is accepted.
- Handshake at edge M (non-final): `osc_en`=0 during M+1, SETTLE from M+2. Per-tap period is 2+SETTLE_CYC+gate cycles plus handshake wait.
- Final handshake at edge M: `done`=1 and `busy`=0 during M+1 only. A new `start` is accepted at M+1.
- `result_ready` may be held high permanently; REPORT then lasts exactly 1 cycle.
- `abort` at edge A: IDLE outputs from A+1.

## Test plan
- Single tap: SETTLE_CYC=16, tap 3→3, `gate_len`=100, `osc_in` square wave period 10 clk, ready=1 → one result, tap=3, count 10±1; `done` 1 cycle; `osc_en` high for exactly 16+100+1 cycles.
- Wrapped sweep: 6→1, ready=1 → results in tap order 6,7,0,1. `osc_en` has a 1-cycle low between each pair. `done` follows the tap-1 result.
- Backpressure: ready=0 for 50 cycles in REPORT → `result_valid`, `result_tap`, `result_count` stable. Then ready=1 for 1 cycle → advance to OFF.
- Saturation: CNT_W=4, `gate_len`=200, period 8 → count=15. `gate_len`=0, `osc_in`=0 → GATE lasts 1 cycle, count=0.
- Abort in GATE, and `start` while busy → IDLE next cycle, `osc_en`=0, no `result_valid`, no `done`. `start` during SETTLE does not change the latched range.
- Async `rst` asserted mid-GATE, not clock-aligned → all outputs at reset values immediately. After release, a `start` runs normally.

Source files
------------

// File: rtl/ring_osc_sweep_ctrl.sv
// Tapped ring oscillator sweep sequencer: for each tap in a programmed range it
// enables the ring, lets it settle, counts synchronized oscillator rising edges
// over a gate window and offers (tap, count) on a valid/ready result port.
module ring_osc_sweep_ctrl #(
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [2:0]        i_tap_first,
  input  logic [2:0]        i_tap_last,
  input  logic [GATE_W-1:0] i_gate_len,
  input  logic              i_osc_in,
  output logic              o_osc_en,
  output logic [2:0]        o_tap,
  output logic              o_busy,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic [2:0]        o_result_tap,
  output logic [CNT_W-1:0]  o_result_count,
  output logic              o_done
);

  // One down-counter-free cycle counter is shared by SETTLE and GATE, so it
  // must be wide enough for whichever of the two limits is larger.
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CYC_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_REPORT = 3'd3,
    ST_OFF    = 3'd4
  } state_t;

  state_t             r_state;
  logic [2:0]         r_tap_last;
  logic [GATE_W-1:0]  r_gate_len;
  logic [CYC_W-1:0]   r_cyc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic               r_osc_en;
  logic [2:0]         r_tap;
  logic               r_busy;
  logic               r_result_valid;
  logic [2:0]         r_result_tap;
  logic [CNT_W-1:0]   r_result_count;
  logic               r_done;

  logic               w_edge;
  logic [GATE_W-1:0]  w_gate_eff;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_settle_end;
  logic               w_gate_end;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc);
    if (inc && (cnt != {CNT_W{1'b1}})) begin
      return cnt + CNT_W'(1);
    end else begin
      return cnt;
    end
  endfunction

  assign w_edge       = r_s2 & ~r_s3;
  assign w_gate_eff   = (i_gate_len == {GATE_W{1'b0}}) ? GATE_W'(1) : i_gate_len;
  assign w_cnt_next   = sat_inc(r_cnt, w_edge);
  assign w_settle_end = (r_cyc == SETTLE_LAST);
  assign w_gate_end   = (r_cyc == CYC_W'(r_gate_len - GATE_W'(1)));

  // Synchronize the asynchronous oscillator and keep one delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_osc_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Sweep sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_tap_last     <= 3'd0;
      r_gate_len     <= GATE_W'(1);
      r_cyc          <= {CYC_W{1'b0}};
      r_cnt          <= {CNT_W{1'b0}};
      r_osc_en       <= 1'b0;
      r_tap          <= 3'd0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_tap   <= 3'd0;
      r_result_count <= {CNT_W{1'b0}};
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort && (r_state != ST_IDLE)) begin
        r_state        <= ST_IDLE;
        r_osc_en       <= 1'b0;
        r_busy         <= 1'b0;
        r_result_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_tap_last <= i_tap_last;
              r_gate_len <= w_gate_eff;
              r_tap      <= i_tap_first;
              r_cyc      <= {CYC_W{1'b0}};
              r_osc_en   <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (w_settle_end) begin
              r_cyc   <= {CYC_W{1'b0}};
              r_cnt   <= {CNT_W{1'b0}};
              r_state <= ST_GATE;
            end else begin
              r_cyc <= r_cyc + CYC_W'(1);
            end
          end
          ST_GATE: begin
            if (w_gate_end) begin
              r_result_count <= w_cnt_next;
              r_result_tap   <= r_tap;
              r_result_valid <= 1'b1;
              r_state        <= ST_REPORT;
            end else begin
              r_cnt <= w_cnt_next;
              r_cyc <= r_cyc + CYC_W'(1);
            end
          end
          ST_REPORT: begin
            if (i_result_ready) begin
              r_result_valid <= 1'b0;
              r_osc_en       <= 1'b0;
              if (r_tap == r_tap_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_tap   <= r_tap + 3'd1;
                r_state <= ST_OFF;
              end
            end
          end
          ST_OFF: begin
            // The single low cycle on the enable resets the ring before the new tap.
            r_osc_en <= 1'b1;
            r_cyc    <= {CYC_W{1'b0}};
            r_state  <= ST_SETTLE;
          end
          default: begin
            r_state        <= ST_IDLE;
            r_osc_en       <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_osc_en       = r_osc_en;
  assign o_tap          = r_tap;
  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_result_tap   = r_result_tap;
  assign o_result_count = r_result_count;
  assign o_done         = r_done;

endmodule

// File: tb/tb_ring_osc_sweep_ctrl.sv
// Self-checking bench for ring_osc_sweep_ctrl: table rows, random sweeps and
// hand-written abort / reset sequences against a schedule-based reference model.
module tb_ring_osc_sweep_ctrl;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  tap_first = 3'd0;
  logic [2:0]  tap_last = 3'd0;
  logic [15:0] gate_len = 16'd0;
  logic        osc_in = 1'b0;
  logic        ready = 1'b0;

  logic        osc_en, busy, rvalid, done;
  logic [2:0]  tap, rtap;
  logic [15:0] rcount;
  logic        d4_osc_en, d4_busy, d4_rvalid, d4_done;
  logic [2:0]  d4_tap, d4_rtap;
  logic [3:0]  d4_rcount;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int osc_mode = 0;   // 0: held low, 1: fixed half period, 2: random half periods
  int osc_half = 5;
  int rise_q[$];      // posedge index at which each osc_in rise is first sampled

  ring_osc_sweep_ctrl #(.CNT_W(16), .GATE_W(16), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_tap_first(tap_first), .i_tap_last(tap_last), .i_gate_len(gate_len),
    .i_osc_in(osc_in), .o_osc_en(osc_en), .o_tap(tap), .o_busy(busy),
    .o_result_valid(rvalid), .i_result_ready(ready), .o_result_tap(rtap),
    .o_result_count(rcount), .o_done(done)
  );

  ring_osc_sweep_ctrl #(.CNT_W(4), .GATE_W(16), .SETTLE_CYC(S)) dut4 (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_tap_first(tap_first), .i_tap_last(tap_last), .i_gate_len(gate_len),
    .i_osc_in(osc_in), .o_osc_en(d4_osc_en), .o_tap(d4_tap), .o_busy(d4_busy),
    .o_result_valid(d4_rvalid), .i_result_ready(ready), .o_result_tap(d4_rtap),
    .o_result_count(d4_rcount), .o_done(d4_done)
  );

  initial forever #5 clk = ~clk;

  // Count posedges so far; at a negedge, cyc is the index of the edge just passed.
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator stimulus, driven at negedges; every rise is logged for the model.
  initial begin
    int half_cnt;
    half_cnt = 0;
    forever begin
      @(negedge clk);
      if (osc_mode == 0) begin
        osc_in = 1'b0;
        half_cnt = 0;
      end else begin
        if (half_cnt == 0) begin
          osc_in = ~osc_in;
          if (osc_in) rise_q.push_back(cyc + 1);
          half_cnt = (osc_mode == 1) ? osc_half : int'($urandom_range(3, 6));
        end
        half_cnt = half_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) begin
      n_checks++;
      n_fail++;
      $display("FAIL schedule: at cycle %0d expected %0d", cyc, t);
    end
    while (cyc < t) @(negedge clk);
  endtask

  // Rises whose detect pulse falls inside the gate window [g0, g0+G-1] are counted.
  function automatic int model_count(input int g0, input int g);
    int n;
    n = 0;
    foreach (rise_q[i]) if (rise_q[i] >= g0 - 1 && rise_q[i] <= g0 + g - 2) n++;
    return n;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // wmode: >=0 fixed ready wait per tap, -1 random wait, -2 ready held high.
  task automatic run_sweep(input logic [2:0] f, input logic [2:0] l, input int gate,
                           input int wmode, input bit inject,
                           input int exp_cnt, input int exp_cnt4);
    int n, g, g0, r, w, cnt;
    logic [2:0] t;
    g = (gate == 0) ? 1 : gate;
    n = ((int'(l) - int'(f) + 8) % 8) + 1;
    @(negedge clk);
    tap_first = f; tap_last = l; gate_len = 16'(gate); start = 1'b1;
    ready = (wmode == -2);
    @(negedge clk);
    start = 1'b0;
    tap_first = 3'($urandom); tap_last = 3'($urandom); gate_len = 16'($urandom);
    chk("start_busy", busy, 1);
    chk("start_osc_en", osc_en, 1);
    chk("start_tap", tap, f);
    g0 = cyc + S;
    t = f;
    for (int i = 0; i < n; i++) begin
      if (inject && i == 0) begin
        wait_until(cyc + 2);
        start = 1'b1; tap_first = f + 3'd3; tap_last = f + 3'd4; gate_len = 16'd2;
        @(negedge clk);
        start = 1'b0;
        chk("inject_tap", tap, f);
      end
      r = g0 + g;
      wait_until(r - 1);
      chk("pre_valid", rvalid, 0);
      chk("gate_osc_en", osc_en, 1);
      wait_until(r);
      cnt = model_count(g0, g);
      chk("valid", rvalid, 1);
      chk("result_tap", rtap, t);
      chk("result_count", rcount, cnt);
      chk("result_count4", d4_rcount, sat(cnt, 15));
      if (i == 0 && exp_cnt >= 0) begin
        chk("tbl_count", rcount, exp_cnt);
        chk("tbl_count4", d4_rcount, exp_cnt4);
      end
      w = (wmode >= 0) ? wmode : ((wmode == -1) ? int'($urandom_range(0, 3)) : 0);
      for (int j = 0; j < w; j++) begin
        @(negedge clk);
        chk("hold_valid", rvalid, 1);
        chk("hold_tap", rtap, t);
        chk("hold_count", rcount, cnt);
      end
      ready = 1'b1;
      @(negedge clk);
      if (wmode != -2) ready = 1'b0;
      chk("hs_valid", rvalid, 0);
      chk("hs_osc_en", osc_en, 0);
      if (i == n - 1) begin
        chk("done", done, 1);
        chk("final_busy", busy, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
      end else begin
        chk("off_done", done, 0);
        chk("off_busy", busy, 1);
        t = t + 3'd1;
        chk("next_tap", tap, t);
        g0 = cyc + 1 + S;
        @(negedge clk);
        chk("reenable", osc_en, 1);
      end
    end
  endtask

  typedef struct {
    logic [2:0] f;
    logic [2:0] l;
    int gate;
    int mode;
    int half;
    int wmode;
    bit inject;
    int exp_cnt;
    int exp_cnt4;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int r, a;
    vecs[0] = '{3'd3, 3'd3, 100, 1, 5, 0, 1'b0, 10, 10};
    vecs[1] = '{3'd6, 3'd1, 20, 2, 0, -2, 1'b0, -1, -1};
    vecs[2] = '{3'd2, 3'd4, 30, 2, 0, 50, 1'b0, -1, -1};
    vecs[3] = '{3'd5, 3'd5, 200, 1, 4, 0, 1'b0, 25, 15};
    vecs[4] = '{3'd0, 3'd0, 0, 0, 0, 0, 1'b0, 0, 0};
    vecs[5] = '{3'd1, 3'd0, 5, 2, 0, -1, 1'b0, -1, -1};
    vecs[6] = '{3'd2, 3'd3, 15, 2, 0, -1, 1'b1, -1, -1};

    repeat (3) @(negedge clk);
    chk("rst_osc_en", osc_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rvalid, 0);
    chk("rst_count", rcount, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      osc_mode = vecs[i].mode;
      osc_half = vecs[i].half;
      run_sweep(vecs[i].f, vecs[i].l, vecs[i].gate, vecs[i].wmode, vecs[i].inject,
                vecs[i].exp_cnt, vecs[i].exp_cnt4);
    end

    osc_mode = 2;
    for (int i = 0; i < 6; i++) begin
      run_sweep(3'($urandom), 3'($urandom), int'($urandom_range(0, 40)), -1,
                1'($urandom), -1, -1);
    end

    // Abort mid-GATE with a simultaneous start: abort wins, no result, no done.
    @(negedge clk);
    tap_first = 3'd1; tap_last = 3'd4; gate_len = 16'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = cyc + S + 5;
    wait_until(a);
    abort = 1'b1; start = 1'b1; tap_first = 3'd0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_osc_en", osc_en, 0);
    for (int j = 0; j < 30; j++) begin
      chk("abort_quiet", {rvalid, done, osc_en}, 3'b000);
      @(negedge clk);
    end

    // Abort while a result waits in REPORT.
    tap_first = 3'd2; tap_last = 3'd2; gate_len = 16'd3; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    r = cyc + S + 3;
    wait_until(r);
    chk("rep_valid", rvalid, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rep", {rvalid, done, busy, osc_en}, 4'b0000);

    // Asynchronous reset in the middle of GATE, away from any clock edge.
    osc_mode = 0;
    @(negedge clk);
    tap_first = 3'd3; tap_last = 3'd7; gate_len = 16'd40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(cyc + S + 10);
    #2 rst = 1'b1;
    #1;
    chk("arst_osc_en", osc_en, 0);
    chk("arst_tap", tap, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", rvalid, 0);
    chk("arst_rtap", rtap, 0);
    chk("arst_count", rcount, 0);
    chk("arst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    osc_mode = 2;
    run_sweep(3'd5, 3'd6, 25, -1, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
